// File: rtl/conv_tile_memory.sv
// conv_tile_memory: image/filter operand store and result capture for the convolution datapath.
// Optional result/image readback port enabled by defining CONV_TILE_MEM_READBACK_EN.
`default_nettype none

module conv_tile_memory #(
    parameter int IMG_N  = 4,
    parameter int FLT_K  = 3,
    parameter int DW     = 8,
    parameter int RES_CH = 2,
    parameter int AW     = 6,
    localparam int OUT_N  = IMG_N - FLT_K + 1,
    localparam int IMG_SZ = IMG_N * IMG_N,
    localparam int FLT_SZ = FLT_K * FLT_K,
    localparam int OUT_SZ = OUT_N * OUT_N,
    localparam int RES_W  = RES_CH * OUT_SZ * DW,
    localparam int CHW    = $clog2(RES_CH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic                   load_done,
    input  logic [1:0]             cs,
    input  logic [RES_W-1:0]       res_in,
    output logic [1:0]             ms,
    output logic [IMG_SZ*DW-1:0]   data,
    output logic [FLT_SZ*DW-1:0]   filter,
    output logic [RES_W-1:0]       res_out,
    output logic                   err
`ifdef CONV_TILE_MEM_READBACK_EN
    ,
    input  logic                   rd_en,
    input  logic [CHW-1:0]         rd_ch,
    input  logic [AW-1:0]          rd_addr,
    output logic [DW-1:0]          rd_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_READY = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [AW:0] IMG_LIM = (AW+1)'(IMG_SZ);
    localparam logic [AW:0] FLT_LIM = (AW+1)'(FLT_SZ);

    state_t                 state_q, state_d;
    logic [IMG_SZ*DW-1:0]   data_q, data_d;
    logic [FLT_SZ*DW-1:0]   filt_q, filt_d;
    logic [RES_W-1:0]       res_q, res_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        filt_d  = filt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    data_d  = '0;
                    filt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    if (!wr_sel) begin
                        if ({1'b0, wr_addr} < IMG_LIM) begin
                            for (int i = 0; i < IMG_SZ; i++) begin
                                if (wr_addr == AW'(i)) data_d[i*DW +: DW] = wr_data;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if ({1'b0, wr_addr} < FLT_LIM) begin
                            for (int i = 0; i < FLT_SZ; i++) begin
                                if (wr_addr == AW'(i)) filt_d[i*DW +: DW] = wr_data;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (load_done) state_d = S_READY;
            end
            S_READY: begin
                if (cs == 2'b01) begin
                    res_d   = res_in;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A fresh run wins over the compute block returning to idle.
                if (start) begin
                    state_d = S_LOAD;
                    data_d  = '0;
                    filt_d  = '0;
                    err_d   = 1'b0;
                end else if (cs == 2'b00) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            filt_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            filt_q  <= filt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign ms      = state_q;
    assign data    = data_q;
    assign filter  = filt_q;
    assign res_out = res_q;
    assign err     = err_q;

`ifdef CONV_TILE_MEM_READBACK_EN
    logic [DW-1:0] rd_q, rd_d;

    // Channel index RES_CH addresses the image; anything unmatched reads as zero.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = '0;
            for (int ch = 0; ch < RES_CH; ch++) begin
                for (int i = 0; i < OUT_SZ; i++) begin
                    if (rd_ch == CHW'(ch) && rd_addr == AW'(i))
                        rd_d = res_q[(ch*OUT_SZ+i)*DW +: DW];
                end
            end
            for (int i = 0; i < IMG_SZ; i++) begin
                if (rd_ch == CHW'(RES_CH) && rd_addr == AW'(i))
                    rd_d = data_q[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_d;
    end

    assign rd_data = rd_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_memory.sv
// Scoreboard bench for conv_tile_memory: directed scenarios then random traffic vs. a reference model.
`default_nettype none

module tb_conv_tile_memory;
`ifdef CONV_TILE_MEM_READBACK_EN
    localparam int IMG_N  = 6;
    localparam int FLT_K  = 3;
    localparam int RES_CH = 3;
`else
    localparam int IMG_N  = 4;
    localparam int FLT_K  = 3;
    localparam int RES_CH = 2;
`endif
    localparam int DW     = 8;
    localparam int AW     = 6;
    localparam int OUT_N  = IMG_N - FLT_K + 1;
    localparam int IMG_SZ = IMG_N * IMG_N;
    localparam int FLT_SZ = FLT_K * FLT_K;
    localparam int OUT_SZ = OUT_N * OUT_N;
    localparam int RES_N  = RES_CH * OUT_SZ;
    localparam int RES_W  = RES_N * DW;
    localparam int CHW    = $clog2(RES_CH) + 1;

    logic                 clk, rst, start, wr_en, wr_sel, load_done;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [1:0]           cs, ms;
    logic [RES_W-1:0]     res_in, res_out;
    logic [IMG_SZ*DW-1:0] data;
    logic [FLT_SZ*DW-1:0] filter;
    logic                 err;
    logic                 rd_en;
    logic [CHW-1:0]       rd_ch;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_data;

    conv_tile_memory #(
        .IMG_N(IMG_N), .FLT_K(FLT_K), .DW(DW), .RES_CH(RES_CH), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done), .cs(cs),
        .res_in(res_in), .ms(ms), .data(data), .filter(filter), .res_out(res_out),
        .err(err)
`ifdef CONV_TILE_MEM_READBACK_EN
        , .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

`ifndef CONV_TILE_MEM_READBACK_EN
    assign rd_data = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]           ms;
        logic [IMG_SZ*DW-1:0] data;
        logic [FLT_SZ*DW-1:0] filt;
        logic [RES_W-1:0]     res;
        logic                 err;
        logic [DW-1:0]        rd;
    } exp_t;

    exp_t sb[$];

    // Reference model: mode 0 idle, 1 loading, 2 ready, 3 done.
    int            m_mode;
    logic [DW-1:0] m_img [IMG_SZ];
    logic [DW-1:0] m_flt [FLT_SZ];
    logic [DW-1:0] m_res [RES_N];
    logic          m_err;
    logic [DW-1:0] m_rd;

    task automatic clear_ops();
        foreach (m_img[i]) m_img[i] = '0;
        foreach (m_flt[i]) m_flt[i] = '0;
        m_err = 1'b0;
    endtask

    function automatic logic [DW-1:0] rd_lookup();
        int ch = int'(rd_ch);
        int a  = int'(rd_addr);
        if (ch == RES_CH && a < IMG_SZ) return m_img[a];
        if (ch < RES_CH && a < OUT_SZ)  return m_res[ch*OUT_SZ + a];
        return '0;
    endfunction

    task automatic model_step();
        int a;
        if (rst) begin
            clear_ops();
            foreach (m_res[i]) m_res[i] = '0;
            m_mode = 0;
            m_rd   = '0;
            return;
        end
`ifdef CONV_TILE_MEM_READBACK_EN
        if (rd_en) m_rd = rd_lookup();
`endif
        case (m_mode)
            0: if (start) begin clear_ops(); m_mode = 1; end
            1: begin
                if (wr_en) begin
                    a = int'(wr_addr);
                    if (!wr_sel) begin
                        if (a < IMG_SZ) m_img[a] = wr_data; else m_err = 1'b1;
                    end else begin
                        if (a < FLT_SZ) m_flt[a] = wr_data; else m_err = 1'b1;
                    end
                end
                if (load_done) m_mode = 2;
            end
            2: if (cs == 2'b01) begin
                for (int k = 0; k < RES_N; k++) m_res[k] = res_in[k*DW +: DW];
                m_mode = 3;
            end
            default: begin
                if (start) begin clear_ops(); m_mode = 1; end
                else if (cs == 2'b00) m_mode = 0;
            end
        endcase
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.ms   = 2'(m_mode);
        e.data = '0;
        e.filt = '0;
        e.res  = '0;
        for (int i = 0; i < IMG_SZ; i++) e.data[i*DW +: DW] = m_img[i];
        for (int i = 0; i < FLT_SZ; i++) e.filt[i*DW +: DW] = m_flt[i];
        for (int i = 0; i < RES_N; i++)  e.res[i*DW +: DW]  = m_res[i];
        e.err = m_err;
        e.rd  = m_rd;
        return e;
    endfunction

    // Apply the currently driven inputs to the model, queue the expected result, advance one cycle.
    task automatic cyc();
        model_step();
        sb.push_back(snapshot());
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ms",      512'(ms),      512'(e.ms));
            chk("data",    512'(data),    512'(e.data));
            chk("filter",  512'(filter),  512'(e.filt));
            chk("res_out", 512'(res_out), 512'(e.res));
            chk("err",     512'(err),     512'(e.err));
`ifdef CONV_TILE_MEM_READBACK_EN
            chk("rd_data", 512'(rd_data), 512'(e.rd));
`endif
        end
    end

    function automatic logic [RES_W-1:0] rand_res();
        logic [RES_W-1:0] r;
        for (int i = 0; i < RES_N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic quiet();
        rst = 1'b0; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; load_done = 1'b0;
        wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
    endtask

    task automatic wr(input logic sel, input int addr, input int val);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = DW'(val);
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        quiet();
        cs = 2'b00;
        res_in = '0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset mid-LOAD after three image writes.
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 3; i++) wr(1'b0, i, $urandom_range(1, 255));
        rst = 1'b1; cyc(); rst = 1'b0;

        // Full load of image and filter.
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < IMG_SZ; i++)
            wr(1'b0, i, (i == 0) ? 41 : (i == 1) ? 35 : (i == 2) ? 190 :
                        (i == IMG_SZ-1) ? 235 : int'($urandom_range(0, 255)));
        for (int i = 0; i < FLT_SZ; i++)
            wr(1'b1, i, (i == 0) ? 179 : (i == FLT_SZ-1) ? 36 : int'($urandom_range(0, 255)));
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(IMG_SZ); cs = 2'b01;
        start = 1'b1; cyc(); start = 1'b0; wr_en = 1'b0; cs = 2'b00;
        load_done = 1'b1; cyc(); load_done = 1'b0;

        // Capture, hold with cs=01, then return to idle.
        for (int i = 0; i < RES_W / 32; i++) res_in[i*32 +: 32] = 32'hA1B2C3D4;
        cs = 2'b01; cyc();
        res_in = rand_res(); cyc(); cyc();
        wr_en = 1'b1; wr_addr = '1; cyc(); wr_en = 1'b0;
        cs = 2'b00; cyc();

        // Out-of-range filter write, then image write together with load_done.
        start = 1'b1; cyc(); start = 1'b0;
        wr(1'b1, FLT_SZ, 7);
        load_done = 1'b1; wr(1'b0, IMG_SZ-1, 99); load_done = 1'b0;
        res_in = rand_res(); cs = 2'b01; cyc();

`ifdef CONV_TILE_MEM_READBACK_EN
        rd_en = 1'b1; rd_ch = CHW'(2); rd_addr = AW'(8); cyc();
        rd_addr = AW'(9); cyc();
        rd_addr = AW'(OUT_SZ); cyc();
        rd_ch = CHW'(RES_CH); rd_addr = AW'(IMG_SZ-1); cyc();
        rd_ch = CHW'(RES_CH+1); rd_addr = '0; cyc();
        rd_en = 1'b0; cyc();
`endif

        // DONE with start and cs=00 together.
        start = 1'b1; cs = 2'b00; cyc(); start = 1'b0;
        load_done = 1'b1; cyc(); load_done = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 7) == 0);
            wr_en     = 1'($urandom);
            wr_sel    = 1'($urandom);
            wr_addr   = AW'($urandom_range(0, IMG_SZ + 3));
            wr_data   = DW'($urandom);
            load_done = ($urandom_range(0, 9) == 0);
            cs        = 2'($urandom);
            res_in    = rand_res();
            rd_en     = 1'($urandom);
            rd_ch     = CHW'($urandom_range(0, RES_CH + 1));
            rd_addr   = AW'($urandom_range(0, IMG_SZ + 2));
            cyc();
        end
        quiet();

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
